tlb_lookup: RTL and testbench

- Joint TLB array that answers translation searches issued by the instruction-side and data-side MMUs.
- The ports are the other end of the s_vpn/s_odd/s_asid → s_found/s_index/s_pfn/s_c/s_d/s_v lookup interface.
- Also services the CP0 TLB instructions: TLBWI/TLBWR write, TLBR read, and TLBP probe (via port 1).
- Holds the Random index counter bounded below by Wired.

---
 rtl/tlb_lookup_if.sv | 82 ++++++++
 rtl/tlb_lookup.sv | 159 +++++++++++++++
 tb/tb_tlb_lookup.sv | 340 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tlb_lookup_if.sv
// Bundles the TLB search, write, read and Random buses between the MMUs/CP0 and the TLB array.
// With TLB_STAT_EN defined, the per-port miss counters travel on this interface too.
interface tlb_lookup_if #(
    parameter int TLBNUM = 16
);
    localparam int IW = $clog2(TLBNUM);

    logic [18:0]   s0_vpn;
    logic          s0_odd;
    logic [7:0]    s0_asid;
    logic          s0_en;
    logic          s0_found;
    logic [IW-1:0] s0_index;
    logic [19:0]   s0_pfn;
    logic [2:0]    s0_c;
    logic          s0_d;
    logic          s0_v;

    logic [18:0]   s1_vpn;
    logic          s1_odd;
    logic [7:0]    s1_asid;
    logic          s1_en;
    logic          s1_found;
    logic [IW-1:0] s1_index;
    logic [19:0]   s1_pfn;
    logic [2:0]    s1_c;
    logic          s1_d;
    logic          s1_v;

    logic          we;
    logic [IW-1:0] w_index;
    logic [77:0]   w_entry;
    logic          r_req;
    logic [IW-1:0] r_index;
    logic          r_valid;
    logic [77:0]   r_entry;
    logic [IW-1:0] wired;
    logic          wired_we;
    logic [IW-1:0] random_index;

`ifdef TLB_STAT_EN
    logic [31:0]   s0_miss_cnt;
    logic [31:0]   s1_miss_cnt;

    modport slave (
        input  s0_vpn, s0_odd, s0_asid, s0_en,
        output s0_found, s0_index, s0_pfn, s0_c, s0_d, s0_v,
        input  s1_vpn, s1_odd, s1_asid, s1_en,
        output s1_found, s1_index, s1_pfn, s1_c, s1_d, s1_v,
        input  we, w_index, w_entry, r_req, r_index, wired, wired_we,
        output r_valid, r_entry, random_index, s0_miss_cnt, s1_miss_cnt
    );

    modport master (
        output s0_vpn, s0_odd, s0_asid, s0_en,
        input  s0_found, s0_index, s0_pfn, s0_c, s0_d, s0_v,
        output s1_vpn, s1_odd, s1_asid, s1_en,
        input  s1_found, s1_index, s1_pfn, s1_c, s1_d, s1_v,
        output we, w_index, w_entry, r_req, r_index, wired, wired_we,
        input  r_valid, r_entry, random_index, s0_miss_cnt, s1_miss_cnt
    );
`else
    modport slave (
        input  s0_vpn, s0_odd, s0_asid, s0_en,
        output s0_found, s0_index, s0_pfn, s0_c, s0_d, s0_v,
        input  s1_vpn, s1_odd, s1_asid, s1_en,
        output s1_found, s1_index, s1_pfn, s1_c, s1_d, s1_v,
        input  we, w_index, w_entry, r_req, r_index, wired, wired_we,
        output r_valid, r_entry, random_index
    );

    modport master (
        output s0_vpn, s0_odd, s0_asid, s0_en,
        input  s0_found, s0_index, s0_pfn, s0_c, s0_d, s0_v,
        output s1_vpn, s1_odd, s1_asid, s1_en,
        input  s1_found, s1_index, s1_pfn, s1_c, s1_d, s1_v,
        output we, w_index, w_entry, r_req, r_index, wired, wired_we,
        input  r_valid, r_entry, random_index
    );
`endif

endinterface

// File: rtl/tlb_lookup.sv
// Joint I/D TLB: two zero-latency search ports, TLBWI/TLBWR write, TLBR read and the Random counter.
// Optional per-port miss statistics are enabled with the TLB_STAT_EN macro.
module tlb_lookup #(
    parameter int TLBNUM = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    tlb_lookup_if.slave  bus
);
    localparam int IW = $clog2(TLBNUM);
    localparam logic [IW-1:0] RAND_TOP = IW'(TLBNUM - 1);

    typedef struct packed {
        logic          found;
        logic [IW-1:0] index;
        logic [19:0]   pfn;
        logic [2:0]    c;
        logic          d;
        logic          v;
    } search_res_t;

    logic [77:0]   entry_q [TLBNUM];
    logic          r_valid_q;
    logic [77:0]   r_entry_q;
    logic [IW-1:0] rand_q;
    logic [IW-1:0] rand_d;
    search_res_t   s0_res;
    search_res_t   s1_res;

    // Scan from the top down so the lowest matching index is the one left standing.
    function automatic search_res_t lookup(input logic [18:0] vpn,
                                           input logic        odd,
                                           input logic [7:0]  asid);
        search_res_t res;
        search_res_t cand;
        logic        hit;
        res = '0;
        for (int i = TLBNUM - 1; i >= 0; i--) begin
            hit        = (entry_q[i][77:59] == vpn) &&
                         (entry_q[i][50] || (entry_q[i][58:51] == asid));
            cand.found = 1'b1;
            cand.index = IW'(i);
            cand.pfn   = odd ? entry_q[i][24:5] : entry_q[i][49:30];
            cand.c     = odd ? entry_q[i][4:2]  : entry_q[i][29:27];
            cand.d     = odd ? entry_q[i][1]    : entry_q[i][26];
            cand.v     = odd ? entry_q[i][0]    : entry_q[i][25];
            res        = hit ? cand : res;
        end
        return res;
    endfunction

    // Port 0 (instruction side) combinational search.
    always_comb begin
        s0_res = lookup(bus.s0_vpn, bus.s0_odd, bus.s0_asid);
    end

    // Port 1 (data side and TLBP) combinational search.
    always_comb begin
        s1_res = lookup(bus.s1_vpn, bus.s1_odd, bus.s1_asid);
    end

    assign bus.s0_found = s0_res.found;
    assign bus.s0_index = s0_res.index;
    assign bus.s0_pfn   = s0_res.pfn;
    assign bus.s0_c     = s0_res.c;
    assign bus.s0_d     = s0_res.d;
    assign bus.s0_v     = s0_res.v;
    assign bus.s1_found = s1_res.found;
    assign bus.s1_index = s1_res.index;
    assign bus.s1_pfn   = s1_res.pfn;
    assign bus.s1_c     = s1_res.c;
    assign bus.s1_d     = s1_res.d;
    assign bus.s1_v     = s1_res.v;

    // Entry storage: TLBWI/TLBWR land at the edge, so same-cycle searches see old contents.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < TLBNUM; i++) begin
                entry_q[i] <= 78'd0;
            end
        end else if (bus.we) begin
            entry_q[bus.w_index] <= bus.w_entry;
        end else begin
            entry_q[bus.w_index] <= entry_q[bus.w_index];
        end
    end

    // TLBR: one-cycle read of the pre-write entry; data holds when no request is made.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid_q <= 1'b0;
            r_entry_q <= 78'd0;
        end else if (bus.r_req) begin
            r_valid_q <= 1'b1;
            r_entry_q <= entry_q[bus.r_index];
        end else begin
            r_valid_q <= 1'b0;
            r_entry_q <= r_entry_q;
        end
    end

    assign bus.r_valid = r_valid_q;
    assign bus.r_entry = r_entry_q;

    // Random walks down from the top and wraps once it reaches Wired, keeping wired entries safe.
    always_comb begin
        if (bus.wired_we) begin
            rand_d = RAND_TOP;
        end else if (bus.wired >= RAND_TOP) begin
            rand_d = RAND_TOP;
        end else if (rand_q <= bus.wired) begin
            rand_d = RAND_TOP;
        end else begin
            rand_d = rand_q - IW'(1);
        end
    end

    // Random counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rand_q <= RAND_TOP;
        end else begin
            rand_q <= rand_d;
        end
    end

    assign bus.random_index = rand_q;

`ifdef TLB_STAT_EN
    logic [31:0] s0_miss_q;
    logic [31:0] s1_miss_q;

    // Saturating miss counters, qualified by each port's lookup enable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s0_miss_q <= 32'd0;
            s1_miss_q <= 32'd0;
        end else begin
            if (bus.s0_en && !s0_res.found && (s0_miss_q != 32'hFFFF_FFFF)) begin
                s0_miss_q <= s0_miss_q + 32'd1;
            end else begin
                s0_miss_q <= s0_miss_q;
            end
            if (bus.s1_en && !s1_res.found && (s1_miss_q != 32'hFFFF_FFFF)) begin
                s1_miss_q <= s1_miss_q + 32'd1;
            end else begin
                s1_miss_q <= s1_miss_q;
            end
        end
    end

    assign bus.s0_miss_cnt = s0_miss_q;
    assign bus.s1_miss_cnt = s1_miss_q;
`else
    logic unused_en;
    assign unused_en = bus.s0_en ^ bus.s1_en;
`endif

endmodule

// File: tb/tb_tlb_lookup.sv
// Self-checking bench for tlb_lookup: directed test-plan scenarios plus randomized traffic
// compared against an entry-array reference model.
module tb_tlb_lookup;
    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_fail;

    logic [77:0] model [16];

    tlb_lookup_if #(.TLBNUM(16)) bus ();

    tlb_lookup #(.TLBNUM(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [77:0] mk(input logic [18:0] vpn2, input logic [7:0] asid,
                                       input logic g,
                                       input logic [19:0] pfn0, input logic [2:0] c0,
                                       input logic d0, input logic v0,
                                       input logic [19:0] pfn1, input logic [2:0] c1,
                                       input logic d1, input logic v1);
        return {vpn2, asid, g, pfn0, c0, d0, v0, pfn1, c1, d1, v1};
    endfunction

    // Reference search: first matching entry in ascending index order.
    function automatic logic [29:0] model_search(input logic [18:0] vpn, input logic odd,
                                                 input logic [7:0] asid);
        logic [77:0] e;
        for (int i = 0; i < 16; i++) begin
            e = model[i];
            if (e[77:59] == vpn && (e[50] || e[58:51] == asid)) begin
                if (odd)
                    return {1'b1, 4'(i), e[24:5], e[4:2], e[1], e[0]};
                else
                    return {1'b1, 4'(i), e[49:30], e[29:27], e[26], e[25]};
            end
        end
        return 30'd0;
    endfunction

    function automatic logic [29:0] p0();
        return {bus.s0_found, bus.s0_index, bus.s0_pfn, bus.s0_c, bus.s0_d, bus.s0_v};
    endfunction

    function automatic logic [29:0] p1();
        return {bus.s1_found, bus.s1_index, bus.s1_pfn, bus.s1_c, bus.s1_d, bus.s1_v};
    endfunction

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        bus.s0_vpn = 19'd0; bus.s0_odd = 1'b0; bus.s0_asid = 8'd0; bus.s0_en = 1'b0;
        bus.s1_vpn = 19'd0; bus.s1_odd = 1'b0; bus.s1_asid = 8'd0; bus.s1_en = 1'b0;
        bus.we = 1'b0; bus.w_index = 4'd0; bus.w_entry = 78'd0;
        bus.r_req = 1'b0; bus.r_index = 4'd0;
        bus.wired = 4'd0; bus.wired_we = 1'b0;
    endtask

    task automatic write_entry(input logic [3:0] idx, input logic [77:0] e);
        bus.we = 1'b1; bus.w_index = idx; bus.w_entry = e;
        tick();
        model[idx] = e;
        bus.we = 1'b0;
    endtask

    task automatic search(input logic [18:0] vpn, input logic odd, input logic [7:0] asid);
        bus.s0_vpn = vpn; bus.s0_odd = odd; bus.s0_asid = asid;
        bus.s1_vpn = vpn; bus.s1_odd = odd; bus.s1_asid = asid;
        #1;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        for (int i = 0; i < 16; i++) model[i] = 78'd0;
        repeat (2) @(negedge clk);
        search(19'h00400, 1'b0, 8'h05);
        n_cmp++;
        if (bus.r_valid !== 1'b0 || bus.r_entry !== 78'd0) begin
            n_fail++;
            $display("FAIL reset_read got valid=%b entry=%h want 0/0", bus.r_valid, bus.r_entry);
        end
        n_cmp++;
        if (bus.random_index !== 4'd15) begin
            n_fail++;
            $display("FAIL reset_random got %0d want 15", bus.random_index);
        end
        n_cmp++;
        if (bus.s0_found !== 1'b0 || bus.s0_pfn !== 20'd0 || p1() !== 30'd0) begin
            n_fail++;
            $display("FAIL reset_search got p0=%h p1=%h want 0", p0(), p1());
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_directed_search();
        write_entry(4'd3, mk(19'h00400, 8'h05, 1'b0, 20'h12345, 3'd3, 1'b0, 1'b1,
                             20'h54321, 3'd0, 1'b0, 1'b0));
        search(19'h00400, 1'b0, 8'h05);
        n_cmp++;
        if (p0() !== {1'b1, 4'd3, 20'h12345, 3'd3, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL even_page got %h want %h", p0(),
                     {1'b1, 4'd3, 20'h12345, 3'd3, 1'b0, 1'b1});
        end
        search(19'h00400, 1'b1, 8'h05);
        n_cmp++;
        if (p1() !== {1'b1, 4'd3, 20'h54321, 3'd0, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL odd_page got %h want %h", p1(),
                     {1'b1, 4'd3, 20'h54321, 3'd0, 1'b0, 1'b0});
        end
        search(19'h00400, 1'b0, 8'h06);
        n_cmp++;
        if (p0() !== 30'd0 || p1() !== 30'd0) begin
            n_fail++;
            $display("FAIL asid_miss got p0=%h p1=%h want 0", p0(), p1());
        end
        tick();
    endtask

    task automatic test_global_priority();
        write_entry(4'd3, mk(19'h00400, 8'h05, 1'b1, 20'h12345, 3'd3, 1'b0, 1'b1,
                             20'h54321, 3'd0, 1'b0, 1'b0));
        search(19'h00400, 1'b0, 8'hAA);
        n_cmp++;
        if (bus.s0_found !== 1'b1 || bus.s0_index !== 4'd3) begin
            n_fail++;
            $display("FAIL global_hit got found=%b idx=%0d want 1/3", bus.s0_found, bus.s0_index);
        end
        write_entry(4'd1, mk(19'h00400, 8'h05, 1'b0, 20'hABCDE, 3'd2, 1'b1, 1'b1,
                             20'h0F0F0, 3'd1, 1'b0, 1'b1));
        search(19'h00400, 1'b0, 8'h05);
        n_cmp++;
        if (bus.s0_index !== 4'd1 || bus.s1_index !== 4'd1 || p0() !== model_search(19'h00400, 1'b0, 8'h05)) begin
            n_fail++;
            $display("FAIL multi_hit got idx0=%0d idx1=%0d want 1", bus.s0_index, bus.s1_index);
        end
        search(19'h00400, 1'b1, 8'hAA);
        n_cmp++;
        if (p1() !== {1'b1, 4'd3, 20'h54321, 3'd0, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL global_only got %h want idx 3", p1());
        end
        tick();
    endtask

    task automatic test_same_cycle_write();
        bus.we = 1'b1; bus.w_index = 4'd7;
        bus.w_entry = mk(19'h07777, 8'h11, 1'b0, 20'h77777, 3'd5, 1'b1, 1'b1,
                         20'h66666, 3'd4, 1'b0, 1'b1);
        search(19'h07777, 1'b0, 8'h11);
        n_cmp++;
        if (bus.s0_found !== 1'b0) begin
            n_fail++;
            $display("FAIL write_bypass got found=%b want 0", bus.s0_found);
        end
        tick();
        model[7] = bus.w_entry;
        bus.we = 1'b0;
        #1;
        n_cmp++;
        if (bus.s0_found !== 1'b1 || bus.s0_index !== 4'd7) begin
            n_fail++;
            $display("FAIL write_visible got found=%b idx=%0d want 1/7", bus.s0_found, bus.s0_index);
        end
        tick();
    endtask

    task automatic test_read();
        logic [77:0] old_e;
        logic [77:0] new_e;
        bus.r_req = 1'b1; bus.r_index = 4'd3;
        tick();
        bus.r_req = 1'b0;
        n_cmp++;
        if (bus.r_valid !== 1'b1 || bus.r_entry !== model[3]) begin
            n_fail++;
            $display("FAIL read got valid=%b entry=%h want 1/%h", bus.r_valid, bus.r_entry, model[3]);
        end
        old_e = model[3];
        new_e = mk(19'h12345, 8'h33, 1'b0, 20'hFEDCB, 3'd7, 1'b1, 1'b0, 20'h13579, 3'd6, 1'b1, 1'b1);
        bus.r_req = 1'b1; bus.r_index = 4'd3;
        bus.we = 1'b1; bus.w_index = 4'd3; bus.w_entry = new_e;
        tick();
        model[3] = new_e;
        bus.we = 1'b0;
        n_cmp++;
        if (bus.r_valid !== 1'b1 || bus.r_entry !== old_e) begin
            n_fail++;
            $display("FAIL read_vs_write got entry=%h want old %h", bus.r_entry, old_e);
        end
        tick();
        bus.r_req = 1'b0;
        n_cmp++;
        if (bus.r_entry !== new_e) begin
            n_fail++;
            $display("FAIL read_after_write got %h want %h", bus.r_entry, new_e);
        end
        tick();
        n_cmp++;
        if (bus.r_valid !== 1'b0 || bus.r_entry !== new_e) begin
            n_fail++;
            $display("FAIL read_hold got valid=%b entry=%h want 0/%h", bus.r_valid, bus.r_entry, new_e);
        end
    endtask

    task automatic test_random_counter();
        bus.wired = 4'd4; bus.wired_we = 1'b1;
        tick();
        bus.wired_we = 1'b0;
        // Random cycles through Wired..15, a period of 16 - Wired.
        for (int k = 0; k < 30; k++) begin
            n_cmp++;
            if (bus.random_index !== 4'(15 - (k % 12))) begin
                n_fail++;
                $display("FAIL random k=%0d got %0d want %0d", k, bus.random_index, 15 - (k % 12));
            end
            tick();
        end
        bus.wired = 4'd15; bus.wired_we = 1'b1;
        tick();
        bus.wired_we = 1'b0;
        for (int k = 0; k < 5; k++) begin
            n_cmp++;
            if (bus.random_index !== 4'd15) begin
                n_fail++;
                $display("FAIL random_held k=%0d got %0d want 15", k, bus.random_index);
            end
            tick();
        end
        bus.wired = 4'd0;
    endtask

    task automatic test_random_traffic();
        logic [18:0] pool [4];
        logic [29:0] e0;
        logic [29:0] e1;
        logic [77:0] we_e;
        pool[0] = 19'h00400; pool[1] = 19'h7FFFF; pool[2] = 19'h01234; pool[3] = 19'h00000;
        for (int n = 0; n < 300; n++) begin
            we_e = {$urandom, $urandom, $urandom};
            we_e[77:59] = pool[$urandom_range(0, 3)];
            we_e[58:51] = 8'($urandom_range(0, 2));
            bus.we = ($urandom_range(0, 2) == 0);
            bus.w_index = 4'($urandom_range(0, 15));
            bus.w_entry = we_e;
            bus.s0_vpn = pool[$urandom_range(0, 3)]; bus.s0_odd = 1'($urandom);
            bus.s0_asid = 8'($urandom_range(0, 2));
            bus.s1_vpn = pool[$urandom_range(0, 3)]; bus.s1_odd = 1'($urandom);
            bus.s1_asid = 8'($urandom_range(0, 2));
            #1;
            e0 = model_search(bus.s0_vpn, bus.s0_odd, bus.s0_asid);
            e1 = model_search(bus.s1_vpn, bus.s1_odd, bus.s1_asid);
            n_cmp++;
            if (p0() !== e0) begin
                n_fail++;
                $display("FAIL rand_p0 n=%0d got %h want %h", n, p0(), e0);
            end
            n_cmp++;
            if (p1() !== e1) begin
                n_fail++;
                $display("FAIL rand_p1 n=%0d got %h want %h", n, p1(), e1);
            end
            tick();
            if (bus.we) model[bus.w_index] = we_e;
        end
        bus.we = 1'b0;
    endtask

    task automatic test_reset_mid_read();
        bus.r_req = 1'b1; bus.r_index = 4'd3;
        #2;
        rst_n = 1'b0;
        for (int i = 0; i < 16; i++) model[i] = 78'd0;
        @(posedge clk);
        @(negedge clk);
        bus.r_req = 1'b0;
        rst_n = 1'b1;
        search(19'h00400, 1'b0, 8'h05);
        n_cmp++;
        if (bus.r_valid !== 1'b0 || bus.r_entry !== 78'd0) begin
            n_fail++;
            $display("FAIL reset_mid_read got valid=%b entry=%h want 0/0", bus.r_valid, bus.r_entry);
        end
        n_cmp++;
        if (p0() !== 30'd0 || bus.random_index !== 4'd15) begin
            n_fail++;
            $display("FAIL reset_clears got p0=%h rand=%0d want 0/15", p0(), bus.random_index);
        end
        tick();
    endtask

`ifdef TLB_STAT_EN
    task automatic test_stats();
        logic [31:0] s0_before;
        s0_before = bus.s0_miss_cnt;
        bus.s1_en = 1'b1;
        search(19'h55555, 1'b0, 8'h99);
        repeat (10) tick();
        bus.s1_en = 1'b0;
        n_cmp++;
        if (bus.s1_miss_cnt !== 32'd10 || bus.s0_miss_cnt !== s0_before) begin
            n_fail++;
            $display("FAIL miss_cnt got s1=%0d s0=%0d want 10/%0d", bus.s1_miss_cnt,
                     bus.s0_miss_cnt, s0_before);
        end
    endtask
`endif

    initial begin
        n_cmp = 0;
        n_fail = 0;
        rst_n = 1'b0;
        test_reset();
        test_directed_search();
        test_global_priority();
        test_same_cycle_write();
        test_read();
        test_random_counter();
        test_random_traffic();
        test_reset_mid_read();
`ifdef TLB_STAT_EN
        test_stats();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
